// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: round-robin between ALU and load unit, one registered
// write per cycle, with a pending-write scoreboard and a saturating lost-arbitration counter.
module wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic [31:0]       busy,
    output logic [15:0]       stall_count
);

    // prio: 0 = ALU preferred on contention, 1 = MEM preferred
    logic              prio;
    logic              accept;
    logic [ADDR_W-1:0] acc_reg;
    logic [DATA_W-1:0] acc_data;
    logic              stall;
    logic [31:0]       busy_d;

    always_comb begin
        alu_ready = ~rst & alu_valid & (~mem_valid | ~prio);
        mem_ready = ~rst & mem_valid & (~alu_valid | prio);
        accept    = alu_ready | mem_ready;
        acc_reg   = mem_ready ? mem_reg : alu_reg;
        acc_data  = mem_ready ? mem_data : alu_data;
        stall     = (alu_valid & ~alu_ready) | (mem_valid & ~mem_ready);
    end

    always_comb begin
        busy_d = busy;
        for (int i = 1; i < 32; i++) begin
            if (accept && acc_reg == ADDR_W'(i)) busy_d[i] = 1'b0;
            // Set is applied after clear so a same-cycle issue keeps the register marked.
            if (issue_valid && issue_reg == ADDR_W'(i)) busy_d[i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio        <= 1'b0;
            RegWrite    <= 1'b0;
            WriteReg    <= '0;
            WriteData   <= '0;
            busy        <= '0;
            stall_count <= '0;
        end else begin
            if (accept) begin
                prio      <= alu_ready;
                WriteReg  <= acc_reg;
                WriteData <= acc_data;
            end
            // Register 0 is hardwired, so an accepted write to it is dropped here.
            RegWrite <= accept && (acc_reg != '0);
            busy     <= busy_d;
            if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized plus directed bench for wb_arbiter: a scoreboard queue carries the expected
// registered outputs from the reference model to an independent monitor process.
module tb_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              alu_valid = 1'b0;
    logic [ADDR_W-1:0] alu_reg = '0;
    logic [DATA_W-1:0] alu_data = '0;
    logic              alu_ready;
    logic              mem_valid = 1'b0;
    logic [ADDR_W-1:0] mem_reg = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic              mem_ready;
    logic              issue_valid = 1'b0;
    logic [ADDR_W-1:0] issue_reg = '0;
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [31:0]       busy;
    logic [15:0]       stall_count;

    wb_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .mem_valid  (mem_valid),
        .mem_reg    (mem_reg),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .issue_valid(issue_valid),
        .issue_reg  (issue_reg),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .busy       (busy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [31:0] busy;
        logic [15:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model state: who won the last grant, which registers await a write, etc.
    int   last_winner;  // 0 = ALU, 1 = MEM
    bit   pending[32];
    int   stall_ref;
    int   lose_alu, lose_mem, max_lose;
    bit   alu_acc, mem_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        last_winner = 1;  // ALU is favoured out of reset
        foreach (pending[i]) pending[i] = 1'b0;
        stall_ref = 0;
        lose_alu  = 0;
        lose_mem  = 0;
        alu_acc   = 1'b0;
        mem_acc   = 1'b0;
    endtask

    // Drive one cycle of stimulus, check the grant, and queue the expected post-edge state.
    task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic iv, input logic [4:0] ir);
        exp_t e;
        bit   win_a, win_m;
        @(posedge clk);
        #2;
        alu_valid   = av;
        alu_reg     = ar;
        alu_data    = ad;
        mem_valid   = mv;
        mem_reg     = mr;
        mem_data    = md;
        issue_valid = iv;
        issue_reg   = ir;
        #1;
        win_a = av && (!mv || last_winner == 1);
        win_m = mv && (!av || last_winner == 0);
        chk("alu_ready", alu_ready, win_a);
        chk("mem_ready", mem_ready, win_m);
        e.we = 1'b0;
        e.wreg = 5'd0;
        e.wdata = 32'd0;
        if (win_a || win_m) begin
            e.wreg      = win_a ? ar : mr;
            e.wdata     = win_a ? ad : md;
            last_winner = win_a ? 0 : 1;
            if (e.wreg != 0) begin
                e.we = 1'b1;
                pending[e.wreg] = 1'b0;
            end
        end
        if (iv && ir != 0) pending[ir] = 1'b1;
        if (((av && !win_a) || (mv && !win_m)) && stall_ref < 65535) stall_ref++;
        lose_alu = (av && !win_a) ? lose_alu + 1 : 0;
        lose_mem = (mv && !win_m) ? lose_mem + 1 : 0;
        if (lose_alu > max_lose) max_lose = lose_alu;
        if (lose_mem > max_lose) max_lose = lose_mem;
        for (int i = 0; i < 32; i++) e.busy[i] = pending[i];
        e.stall = 16'(stall_ref);
        exp_q.push_back(e);
        alu_acc = win_a;
        mem_acc = win_m;
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Asserts reset immediately (asynchronously) and checks everything clears before any edge.
    task automatic do_reset();
        rst       = 1'b1;
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        #1;
        chk("rst_alu_ready", alu_ready, 1'b0);
        chk("rst_mem_ready", mem_ready, 1'b0);
        chk("rst_RegWrite", RegWrite, 1'b0);
        chk("rst_WriteReg", WriteReg, 5'd0);
        chk("rst_WriteData", WriteData, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_stall_count", stall_count, 16'd0);
        exp_q.delete();
        model_reset();
        alu_valid   = 1'b0;
        mem_valid   = 1'b0;
        issue_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("RegWrite", RegWrite, e.we);
                if (e.we) begin
                    chk("WriteReg", WriteReg, e.wreg);
                    chk("WriteData", WriteData, e.wdata);
                end
                chk("busy", busy, e.busy);
                chk("stall_count", stall_count, e.stall);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [3:0]  gseq;
        logic        ra_v, rm_v;
        logic [4:0]  ra_r, rm_r;
        logic [31:0] ra_d, rm_d;
        max_lose = 0;
        #1;
        do_reset();

        // ALU-only write of reg 5
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("single_alu_ready", alu_ready, 1'b1);
        idle();
        chk("single_RegWrite", RegWrite, 1'b1);
        chk("single_WriteReg", WriteReg, 5'd5);
        chk("single_WriteData", WriteData, 32'hDEADBEEF);
        idle();
        chk("single_RegWrite_drop", RegWrite, 1'b0);

        // Contention for four cycles from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 1'b0, 5'd0);
            gseq[i] = mem_ready;
        end
        chk("rr_grant_seq", gseq, 4'b1010);
        idle();
        chk("rr_stall_count", stall_count, 16'd4);

        // Scoreboard set/clear, including set-wins on the same edge
        do_reset();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        idle();
        chk("busy7_set", busy[7], 1'b1);
        cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("busy7_held", busy[7], 1'b1);
        idle();
        chk("busy7_clear", busy[7], 1'b0);
        cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        idle();
        chk("busy9_set_wins", busy[9], 1'b1);
        chk("busy9_RegWrite", RegWrite, 1'b1);

        // Write to reg 0 and issue to reg 0
        do_reset();
        cycle(1'b1, 5'd4, 32'h4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0);
        chk("r0_mem_ready", mem_ready, 1'b1);
        idle();
        chk("r0_RegWrite", RegWrite, 1'b0);
        chk("r0_busy", busy, 32'd0);
        cycle(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0);
        chk("r0_prio_alu", alu_ready, 1'b1);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0);
        idle();

        // Reset asserted mid-cycle right after reg 3 is written
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        cycle(1'b1, 5'd3, 32'h333, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6);
        @(posedge clk);
        #3;
        chk("pre_rst_RegWrite", RegWrite, 1'b1);
        chk("pre_rst_busy6", busy[6], 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("post_rst_RegWrite", RegWrite, 1'b0);
        end

        // Randomized traffic; requesters hold their request until accepted
        do_reset();
        ra_v = 1'b0;
        rm_v = 1'b0;
        ra_r = '0;
        rm_r = '0;
        ra_d = '0;
        rm_d = '0;
        for (int n = 0; n < 2000; n++) begin
            if (!ra_v || alu_acc) begin
                ra_v = ($urandom_range(0, 9) < 6);
                ra_r = 5'($urandom_range(0, 31));
                ra_d = $urandom;
            end
            if (!rm_v || mem_acc) begin
                rm_v = ($urandom_range(0, 9) < 6);
                rm_r = 5'($urandom_range(0, 31));
                rm_d = $urandom;
            end
            cycle(ra_v, ra_r, ra_d, rm_v, rm_r, rm_d,
                  ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
        end
        idle();
        chk("no_starvation", (max_lose <= 1), 1'b1);

        // Long contention drives the stall counter into saturation
        do_reset();
        for (int n = 0; n < 70000; n++) begin
            cycle(1'b1, 5'd10, 32'hAAAA, 1'b1, 5'd11, 32'hBBBB, 1'b0, 5'd0);
        end
        idle();
        chk("stall_saturated", stall_count, 16'hFFFF);

        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, width of write data.
REQ-002 Parameter: ADDR_W, 5, width of register address.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset; asynchronous, active-high.
REQ-005 Port: alu_valid  in  1  ALU writeback request.
REQ-006 Port: alu_reg  in  ADDR_W  ALU destination register.
REQ-007 Port: alu_data  in  DATA_W  ALU result.
REQ-008 Port: alu_ready  out  1  ALU request accepted this cycle.
REQ-009 Port: mem_valid, mem_reg, mem_data, mem_ready  in/in/in/out  1/ADDR_W/DATA_W/1  load-unit writeback, same meaning as ALU ports.
REQ-010 Port: issue_valid  in  1  instruction issued; mark destination busy.
REQ-011 Port: issue_reg  in  ADDR_W  destination of the issued instruction.
REQ-012 Port: RegWrite  out  1  register-file write enable, registered.
REQ-013 Port: WriteReg  out  ADDR_W  register-file write address, registered.
REQ-014 Port: WriteData  out  DATA_W  register-file write data, registered.
REQ-015 Port: busy  out  32  scoreboard; bit n = register n has a pending write.
REQ-016 Port: stall_count  out  16  saturating count of lost-arbitration cycles.

Function
REQ-017 Arbitration SHALL be round-robin via a 1-bit prio register: 0 = ALU preferred, 1 = MEM preferred.
REQ-018 alu_ready SHALL equal alu_valid AND (NOT mem_valid OR prio==0); mem_ready SHALL equal mem_valid AND (NOT alu_valid OR prio==1); both combinational, never both 1.
REQ-019 Acceptance SHALL occur on valid AND ready at a rising edge; at most one acceptance per cycle.
REQ-020 On acceptance prio SHALL toggle to favour the non-granted requester; with no acceptance prio SHALL hold.
REQ-021 Requesters SHALL hold reg/data stable while valid and not ready; the arbiter SHALL NOT buffer unaccepted requests.
REQ-022 Latency SHALL be exactly 1 cycle: the edge that accepts a request drives RegWrite=1, WriteReg, WriteData with the accepted values for one cycle.
REQ-023 With no acceptance RegWrite SHALL be 0 next cycle; WriteReg/WriteData SHALL hold previous values.
REQ-024 A request with reg==0 SHALL be accepted and toggle prio but SHALL produce RegWrite=0.
REQ-025 issue_valid with issue_reg!=0 SHALL set busy[issue_reg] at the next edge; issue_reg==0 SHALL be ignored.
REQ-026 An acceptance SHALL clear busy[reg] at the same edge that asserts RegWrite.
REQ-027 Simultaneous set and clear of the same bit SHALL leave the bit set (set wins).
REQ-028 busy[0] SHALL be constant 0.
REQ-029 stall_count SHALL increment by 1 for each cycle where a requester is valid and not ready; saturates at 0xFFFF, no wrap.
REQ-030 A continuously valid requester SHALL be accepted within 2 cycles (no starvation).

Reset
REQ-031 While rst=1, independent of clk: RegWrite=0, WriteReg=0, WriteData=0, busy=0, prio=0, stall_count=0.
REQ-032 Assertion of rst SHALL discard any in-flight registered write; no RegWrite pulse SHALL follow reset release without a new acceptance.
REQ-033 alu_ready/mem_ready SHALL be 0 while rst=1.

Verification
REQ-034 Reset then ALU-only request alu_reg=5, alu_data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF; following cycle RegWrite=0.
REQ-035 Both valid continuously for 4 cycles from reset (ALU reg 1, MEM reg 2) -> grants ALU, MEM, ALU, MEM; stall_count=4.
REQ-036 issue_valid reg 7, then ALU write reg 7 two cycles later -> busy[7]=1 after issue edge, 0 at write edge; simultaneous issue and write of reg 9 -> busy[9] stays 1.
REQ-037 MEM request reg=0 data=0x1234 -> mem_ready=1, RegWrite stays 0, prio toggles to 0; issue_reg=0 -> busy unchanged.
REQ-038 Assert rst asynchronously mid-cycle after acceptance of reg 3 -> outputs and busy cleared immediately; no RegWrite after release.
REQ-039 Hold ALU and MEM valid for 70000 cycles -> stall_count saturates at 0xFFFF.
